// File: rtl/fetch_redirect_ctrl.sv
// IF-stage sequencer: merges fetch stalls with early (ID) and late (EX) PC redirects,
// parks redirects that arrive while fetch is frozen and squashes wrong-path slots afterwards.
module fetch_redirect_ctrl #(
    parameter int SQUASH_CYCLES = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iready_n,
    input  logic             load_use_hazard,
    input  logic             early_br_req,
    input  logic [31:0]      early_br_target,
    input  logic             late_br_req,
    input  logic [31:0]      late_br_target,
    output logic             keep,
    output logic             nop,
    output logic             branch_PC_early_contral,
    output logic [31:0]      branch_PC_early,
    output logic             branch_PC_contral,
    output logic [31:0]      branch_PC,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, STALL, PEND, SQUASH} state_e;

    localparam logic [3:0] SQ_LOAD     = 4'(SQUASH_CYCLES);
    localparam state_e     AFTER_ISSUE = (SQUASH_CYCLES == 0) ? RUN : SQUASH;

    state_e          state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_late_q, pend_late_d;
    logic [31:0]     pend_target_q, pend_target_d;
    logic [3:0]      sq_cnt_q, sq_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;

    logic        stall_src;
    logic        redir_req;
    logic [31:0] req_target;
    logic        merged_late;
    logic [31:0] merged_target;
    logic        keep_c, nop_c, iss_early, iss_late;
    logic [31:0] iss_target;

    assign stall_src  = iready_n | load_use_hazard;
    assign redir_req  = late_br_req | early_br_req;
    assign req_target = late_br_req ? late_br_target : early_br_target;

    // Pending entry as updated by this cycle's requests: late always replaces, early only replaces early.
    always_comb begin
        merged_late   = pend_late_q;
        merged_target = pend_target_q;
        if (late_br_req) begin
            merged_late   = 1'b1;
            merged_target = late_br_target;
        end else if (early_br_req && !pend_late_q) begin
            merged_late   = 1'b0;
            merged_target = early_br_target;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_late_d   = pend_late_q;
        pend_target_d = pend_target_q;
        sq_cnt_d      = sq_cnt_q;
        keep_c        = 1'b0;
        nop_c         = 1'b0;
        iss_early     = 1'b0;
        iss_late      = 1'b0;
        iss_target    = '0;

        unique case (state_q)
            RUN, STALL: begin
                if (state_q == STALL && stall_src) begin
                    keep_c = 1'b1;
                    nop_c  = iready_n;
                    if (redir_req) begin
                        pend_valid_d  = 1'b1;
                        pend_late_d   = late_br_req;
                        pend_target_d = req_target;
                        state_d       = PEND;
                    end
                end else if (redir_req && !stall_src) begin
                    iss_late   = late_br_req;
                    iss_early  = !late_br_req;
                    iss_target = req_target;
                    nop_c      = 1'b1;
                    sq_cnt_d   = SQ_LOAD;
                    state_d    = AFTER_ISSUE;
                end else if (redir_req) begin
                    keep_c        = 1'b1;
                    nop_c         = 1'b1;
                    pend_valid_d  = 1'b1;
                    pend_late_d   = late_br_req;
                    pend_target_d = req_target;
                    state_d       = PEND;
                end else if (stall_src) begin
                    keep_c  = 1'b1;
                    nop_c   = iready_n;
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end

            PEND: begin
                nop_c = 1'b1;
                if (stall_src) begin
                    keep_c        = 1'b1;
                    pend_late_d   = merged_late;
                    pend_target_d = merged_target;
                end else begin
                    iss_late      = merged_late;
                    iss_early     = !merged_late;
                    iss_target    = merged_target;
                    pend_valid_d  = 1'b0;
                    pend_late_d   = 1'b0;
                    pend_target_d = '0;
                    sq_cnt_d      = SQ_LOAD;
                    state_d       = AFTER_ISSUE;
                end
            end

            SQUASH: begin
                nop_c  = 1'b1;
                keep_c = iready_n;
                // Early requests here come from squashed instructions; only EX can redirect.
                if (late_br_req) begin
                    sq_cnt_d = SQ_LOAD;
                    if (stall_src) begin
                        keep_c        = 1'b1;
                        pend_valid_d  = 1'b1;
                        pend_late_d   = 1'b1;
                        pend_target_d = late_br_target;
                        state_d       = PEND;
                    end else begin
                        keep_c     = 1'b0;
                        iss_late   = 1'b1;
                        iss_target = late_br_target;
                        state_d    = AFTER_ISSUE;
                    end
                end else if (!iready_n) begin
                    if (sq_cnt_q <= 4'd1) begin
                        sq_cnt_d = '0;
                        state_d  = RUN;
                    end else begin
                        sq_cnt_d = sq_cnt_q - 4'd1;
                    end
                end
            end
        endcase
    end

    assign keep                    = rst & keep_c;
    assign nop                     = ~rst | nop_c;
    assign branch_PC_early_contral = rst & iss_early;
    assign branch_PC_contral       = rst & iss_late;
    assign branch_PC_early         = branch_PC_early_contral ? iss_target : '0;
    assign branch_PC               = branch_PC_contral ? iss_target : '0;
    assign redirect_cnt            = redirect_cnt_q;
    assign stall_cnt               = stall_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= RUN;
            pend_valid_q   <= 1'b0;
            pend_late_q    <= 1'b0;
            pend_target_q  <= '0;
            sq_cnt_q       <= '0;
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_late_q   <= pend_late_d;
            pend_target_q <= pend_target_d;
            sq_cnt_q      <= sq_cnt_d;
            if ((branch_PC_contral || branch_PC_early_contral) && redirect_cnt_q != '1)
                redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            if (keep && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: a cycle-by-cycle vector table on the default build,
// plus a narrow-counter, zero-squash instance for saturation and back-to-back redirects.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        iready_n, load_use_hazard;
    logic        early_br_req, late_br_req;
    logic [31:0] early_br_target, late_br_target;

    logic        keep, nop, bec, bc;
    logic [31:0] bpe, bp, rc, sc;
    logic        keep2, nop2, bec2, bc2;
    logic [31:0] bpe2, bp2;
    logic [2:0]  rc2, sc2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk(clk), .rst(rst), .iready_n(iready_n), .load_use_hazard(load_use_hazard),
        .early_br_req(early_br_req), .early_br_target(early_br_target),
        .late_br_req(late_br_req), .late_br_target(late_br_target),
        .keep(keep), .nop(nop),
        .branch_PC_early_contral(bec), .branch_PC_early(bpe),
        .branch_PC_contral(bc), .branch_PC(bp),
        .redirect_cnt(rc), .stall_cnt(sc)
    );

    fetch_redirect_ctrl #(.SQUASH_CYCLES(0), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .iready_n(iready_n), .load_use_hazard(load_use_hazard),
        .early_br_req(early_br_req), .early_br_target(early_br_target),
        .late_br_req(late_br_req), .late_br_target(late_br_target),
        .keep(keep2), .nop(nop2),
        .branch_PC_early_contral(bec2), .branch_PC_early(bpe2),
        .branch_PC_contral(bc2), .branch_PC(bp2),
        .redirect_cnt(rc2), .stall_cnt(sc2)
    );

    // Control group packs {keep, nop, branch_PC_early_contral, branch_PC_contral}.
    localparam logic [3:0] C_IDLE = 4'b0000;
    localparam logic [3:0] C_NOP  = 4'b0100;
    localparam logic [3:0] C_ERLY = 4'b0110;
    localparam logic [3:0] C_LATE = 4'b0101;
    localparam logic [3:0] C_STL  = 4'b1100;
    localparam logic [3:0] C_STLN = 4'b1000;

    typedef struct {
        logic        rst, inr, luh, eq;
        logic [31:0] et;
        logic        lq;
        logic [31:0] lt;
        logic [3:0]  ctl;
        logic [31:0] bet, bt;
        logic        cc;
        int          rc, sc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic ir, input logic lu, input logic eq,
                         input logic [31:0] et, input logic lq, input logic [31:0] lt);
        rst             = r;
        iready_n        = ir;
        load_use_hazard = lu;
        early_br_req    = eq;
        early_br_target = et;
        late_br_req     = lq;
        late_br_target  = lt;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset, then idle run
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 0, 0});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 0, 0});
        // Early branch, one squash slot
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0040, 1'b0, 32'h0, C_ERLY, 32'h0001_0040, 32'h0, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 1, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 1, 0});
        // Simultaneous: late wins, early during SQUASH ignored
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0040, 1'b1, 32'h0001_0100, C_LATE, 32'h0, 32'h0001_0100, 1'b1, 1, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0500, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 2, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 2, 0});
        // Redirect under imem stall
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0001_0200, C_STL, 32'h0, 32'h0, 1'b1, 2, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_STL, 32'h0, 32'h0, 1'b1, 2, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_STL, 32'h0, 32'h0, 1'b1, 2, 2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_LATE, 32'h0, 32'h0001_0200, 1'b1, 2, 3});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 3, 3});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 3, 3});
        // Pending override under load-use stall
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 32'h0001_0080, 1'b0, 32'h0, C_STL, 32'h0, 32'h0, 1'b1, 3, 3});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0001_0300, C_STL, 32'h0, 32'h0, 1'b1, 3, 4});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 32'h0001_0090, 1'b0, 32'h0, C_STL, 32'h0, 32'h0, 1'b1, 3, 5});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, C_STL, 32'h0, 32'h0, 1'b1, 3, 6});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_LATE, 32'h0, 32'h0001_0300, 1'b1, 3, 7});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 4, 7});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 4, 7});
        // Plain stall, zero-cycle release with early issue, squash held by imem stall
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, C_STLN, 32'h0, 32'h0, 1'b1, 4, 7});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_STL, 32'h0, 32'h0, 1'b1, 4, 8});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0400, 1'b0, 32'h0, C_ERLY, 32'h0001_0400, 32'h0, 1'b1, 4, 9});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_STL, 32'h0, 32'h0, 1'b1, 5, 9});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 5, 10});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 5, 10});
        // Late redirect during SQUASH issues at once and reloads the squash count
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0600, 1'b0, 32'h0, C_ERLY, 32'h0001_0600, 32'h0, 1'b1, 5, 10});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0001_0700, C_LATE, 32'h0, 32'h0001_0700, 1'b1, 6, 10});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 7, 10});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 7, 10});
        // Reset while a redirect is pending
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0001_0800, C_STL, 32'h0, 32'h0, 1'b1, 7, 10});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_NOP, 32'h0, 32'h0, 1'b1, 7, 11});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, C_IDLE, 32'h0, 32'h0, 1'b1, 0, 0});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].inr, vecs[i].luh, vecs[i].eq, vecs[i].et, vecs[i].lq, vecs[i].lt);
            #2;
            check($sformatf("v%0d ctl", i), {28'h0, keep, nop, bec, bc}, {28'h0, vecs[i].ctl});
            check($sformatf("v%0d early_tgt", i), bpe, vecs[i].bet);
            check($sformatf("v%0d late_tgt", i), bp, vecs[i].bt);
            if (vecs[i].cc) begin
                check($sformatf("v%0d redirect_cnt", i), rc, 32'(vecs[i].rc));
                check($sformatf("v%0d stall_cnt", i), sc, 32'(vecs[i].sc));
            end
        end

        // Narrow-counter instance: stall counter saturates at 7 and never wraps
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            #2;
            check($sformatf("sat stall_cnt c%0d", c), {29'h0, sc2}, (c < 7) ? 32'(c) : 32'd7);
            check($sformatf("sat keep c%0d", c), {31'h0, keep2}, 32'd1);
        end
        // Release from STALL issues in the same cycle; zero squash returns straight to RUN
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_0040, 1'b0, 32'h0);
        #2;
        check("zsq release ctl", {28'h0, keep2, nop2, bec2, bc2}, {28'h0, C_ERLY});
        check("zsq release tgt", bpe2, 32'h0001_0040);
        check("zsq stall_cnt held", {29'h0, sc2}, 32'd7);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check("zsq next ctl", {28'h0, keep2, nop2, bec2, bc2}, {28'h0, C_IDLE});
        check("zsq redirect_cnt", {29'h0, rc2}, 32'd1);
        // Back-to-back redirects saturate the redirect counter
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_1000 + 32'(k), 1'b0, 32'h0);
            #2;
            check($sformatf("b2b ctl k%0d", k), {28'h0, keep2, nop2, bec2, bc2}, {28'h0, C_ERLY});
            check($sformatf("b2b redirect_cnt k%0d", k), {29'h0, rc2}, (k < 6) ? 32'(k + 1) : 32'd7);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check("b2b redirect_cnt sat", {29'h0, rc2}, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
